// File: rtl/msrv32_pkg.sv
// -----------------------------------------------------------------------------
// msrv32_pkg
// Shared definitions for the msrv32 decode stage:
//   - opcode[6:2] instruction classes
//   - funct3 ALU codes and funct7 qualifiers
//   - bit positions inside wb_mux_sel and imm_type
//   - the decoded control bundle and the buffer entry that carries it
// -----------------------------------------------------------------------------
package msrv32_pkg;

   // opcode[6:2] classes; opcode[1:0] must be 2'b11 for every one of them
   typedef enum logic [4:0] {
      OPC_LOAD     = 5'b00000,
      OPC_MISC_MEM = 5'b00011,
      OPC_OP_IMM   = 5'b00100,
      OPC_AUIPC    = 5'b00101,
      OPC_STORE    = 5'b01000,
      OPC_OP_R     = 5'b01100,
      OPC_LUI      = 5'b01101,
      OPC_BRANCH   = 5'b11000,
      OPC_JALR     = 5'b11001,
      OPC_JAL      = 5'b11011,
      OPC_SYSTEM   = 5'b11100
   } opc_class_e;

   localparam logic [1:0] OPC_QUADRANT = 2'b11;

   // funct3 ALU codes
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   // funct7 qualifiers
   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   // wb_mux_sel bit positions
   localparam int WB_MEM_PC = 0;  // load | auipc | jal | jalr
   localparam int WB_UPPER  = 1;  // lui | auipc
   localparam int WB_CSR_PC = 2;  // csr | jal | jalr

   // imm_type bit positions
   localparam int IMM_I = 0;      // op_imm | load | jalr | branch | jal
   localparam int IMM_S = 1;      // store | branch | csr
   localparam int IMM_U = 2;      // lui | auipc | jal | csr

   // Decoded control bundle. Write enables and is_store are already
   // cleared for illegal instructions.
   typedef struct packed {
      logic [3:0] alu_opcode;
      logic       mul_div;
      logic       is_store;
      logic [1:0] load_size;
      logic       load_unsigned;
      logic       alu_src;
      logic       iadder_src;
      logic       rf_wr_en;
      logic       csr_wr_en;
      logic [2:0] csr_op;
      logic [2:0] wb_mux_sel;
      logic [2:0] imm_type;
      logic       illegal;
   } dec_bundle_t;

   // One elastic-buffer slot
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      dec_bundle_t dec;
   } buf_entry_t;

endpackage

// File: rtl/msrv32_decode_pipe_if.sv
// -----------------------------------------------------------------------------
// msrv32_decode_pipe_if
// Fetch-side and execute-side signals of the decode stage.
//   slave  : view of the decode stage (fetch/execute inputs, decoded outputs)
//   master : view of the surrounding pipeline driving and observing the stage
// Fetch side : instr_in, pc_in, instr_valid_in / instr_ready_out
// Control    : flush_in, trap_taken_in
// Execute    : dec_valid_out / dec_ready_in, decoded head entry, illegal count
// -----------------------------------------------------------------------------
interface msrv32_decode_pipe_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      instr_in;
   logic [31:0]      pc_in;
   logic             instr_valid_in;
   logic             instr_ready_out;
   logic             flush_in;
   logic             trap_taken_in;
   logic             dec_ready_in;
   logic             dec_valid_out;
   logic [31:0]      pc_out;
   logic [31:0]      instr_out;
   logic [3:0]       alu_opcode_out;
   logic             mul_div_out;
   logic             mem_wr_req_out;
   logic [1:0]       load_size_out;
   logic             load_unsigned_out;
   logic             alu_src_out;
   logic             iadder_src_out;
   logic             rf_wr_en_out;
   logic             csr_wr_en_out;
   logic [2:0]       csr_op_out;
   logic [2:0]       wb_mux_sel_out;
   logic [2:0]       imm_type_out;
   logic             illegal_instr_out;
   logic [CNT_W-1:0] illegal_cnt_out;

   modport slave (
      input  instr_in, pc_in, instr_valid_in, flush_in, trap_taken_in, dec_ready_in,
      output instr_ready_out, dec_valid_out, pc_out, instr_out, alu_opcode_out,
             mul_div_out, mem_wr_req_out, load_size_out, load_unsigned_out,
             alu_src_out, iadder_src_out, rf_wr_en_out, csr_wr_en_out, csr_op_out,
             wb_mux_sel_out, imm_type_out, illegal_instr_out, illegal_cnt_out
   );

   modport master (
      output instr_in, pc_in, instr_valid_in, flush_in, trap_taken_in, dec_ready_in,
      input  instr_ready_out, dec_valid_out, pc_out, instr_out, alu_opcode_out,
             mul_div_out, mem_wr_req_out, load_size_out, load_unsigned_out,
             alu_src_out, iadder_src_out, rf_wr_en_out, csr_wr_en_out, csr_op_out,
             wb_mux_sel_out, imm_type_out, illegal_instr_out, illegal_cnt_out
   );
endinterface

// File: rtl/msrv32_instr_decode.sv
// -----------------------------------------------------------------------------
// msrv32_instr_decode
// Purely combinational RV32I (+ optional RV32M) instruction decode.
//   instr : 32-bit instruction word
//   dec   : decoded control bundle including the illegal-instruction flag
// ENABLE_M = 1 accepts OP_R with funct7 = 0000001 as a mul/div op;
// ENABLE_M = 0 treats it as illegal.
// -----------------------------------------------------------------------------
module msrv32_instr_decode
   import msrv32_pkg::*;
#(
   parameter bit ENABLE_M = 1'b1
) (
   input  logic [31:0] instr,
   output dec_bundle_t dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   // Class flags are qualified by the 2'b11 quadrant so that a malformed
   // opcode decodes to no class at all and drives no control bits.
   logic quad_ok;
   logic is_load, is_misc_mem, is_op_imm, is_auipc, is_store, is_op_r;
   logic is_lui, is_branch, is_jalr, is_jal, is_system, is_csr;
   logic known_class;

   assign quad_ok     = (opcode[1:0] == OPC_QUADRANT);
   assign is_load     = quad_ok && (opcode[6:2] == OPC_LOAD);
   assign is_misc_mem = quad_ok && (opcode[6:2] == OPC_MISC_MEM);
   assign is_op_imm   = quad_ok && (opcode[6:2] == OPC_OP_IMM);
   assign is_auipc    = quad_ok && (opcode[6:2] == OPC_AUIPC);
   assign is_store    = quad_ok && (opcode[6:2] == OPC_STORE);
   assign is_op_r     = quad_ok && (opcode[6:2] == OPC_OP_R);
   assign is_lui      = quad_ok && (opcode[6:2] == OPC_LUI);
   assign is_branch   = quad_ok && (opcode[6:2] == OPC_BRANCH);
   assign is_jalr     = quad_ok && (opcode[6:2] == OPC_JALR);
   assign is_jal      = quad_ok && (opcode[6:2] == OPC_JAL);
   assign is_system   = quad_ok && (opcode[6:2] == OPC_SYSTEM);
   assign is_csr      = is_system && (funct3 != 3'b000);

   assign known_class = is_load | is_misc_mem | is_op_imm | is_auipc | is_store |
                        is_op_r | is_lui | is_branch | is_jalr | is_jal | is_system;

   logic is_muldiv;
   assign is_muldiv = is_op_r && (funct7 == F7_MULDIV);

   // Illegal-encoding detection
   logic illegal;
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default
      // first; a path that leaves it unassigned would infer a latch.
      illegal = ~known_class;
      if (is_op_r) begin
         if (!((funct7 == F7_BASE) || (funct7 == F7_ALT) || (ENABLE_M && is_muldiv)))
            illegal = 1'b1;
         // Only ADD/SUB and SRL/SRA have an alternate (bit 30) form
         if ((funct7 == F7_ALT) && (funct3 != F3_ADD) && (funct3 != F3_SR))
            illegal = 1'b1;
      end
      if (is_op_imm) begin
         if ((funct3 == F3_SLL) && (funct7 != F7_BASE))
            illegal = 1'b1;
         if ((funct3 == F3_SR) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
            illegal = 1'b1;
      end
   end

   // For immediate ALU ops other than shifts, bit 30 belongs to the
   // immediate and must not select SUB/SRA.
   logic alt;
   assign alt = (is_op_imm && (funct3 != F3_SLL) && (funct3 != F3_SR)) ? 1'b0 : instr[30];

   always_comb begin
      dec                     = '0;
      dec.alu_opcode          = {alt, funct3};
      dec.mul_div             = ENABLE_M && is_muldiv;
      dec.is_store            = is_store & ~illegal;
      dec.load_size           = funct3[1:0];
      dec.load_unsigned       = funct3[2];
      dec.alu_src             = opcode[5];
      dec.iadder_src          = is_load | is_store | is_jalr;
      dec.rf_wr_en            = (is_lui | is_auipc | is_jal | is_jalr | is_op_r |
                                 is_op_imm | is_load | is_csr) & ~illegal;
      dec.csr_wr_en           = is_csr & ~illegal;
      dec.csr_op              = funct3;
      dec.wb_mux_sel[WB_MEM_PC] = is_load | is_auipc | is_jal | is_jalr;
      dec.wb_mux_sel[WB_UPPER]  = is_lui | is_auipc;
      dec.wb_mux_sel[WB_CSR_PC] = is_csr | is_jal | is_jalr;
      dec.imm_type[IMM_I]       = is_op_imm | is_load | is_jalr | is_branch | is_jal;
      dec.imm_type[IMM_S]       = is_store | is_branch | is_csr;
      dec.imm_type[IMM_U]       = is_lui | is_auipc | is_jal | is_csr;
      dec.illegal             = illegal;
   end

endmodule

// File: rtl/msrv32_decode_pipe.sv
// -----------------------------------------------------------------------------
// msrv32_decode_pipe
// Decode stage: decodes instr_in combinationally and stores the decoded bundle
// (with pc and raw instruction) in a BUF_DEPTH-entry elastic buffer. All
// outputs come from the head entry, so an instruction accepted at one edge is
// visible after that edge.
//   ms_riscv32_mp_clk_in : core clock
//   ms_riscv32_mp_rst_in : synchronous active-high reset
//   bus (slave)          : fetch handshake, flush/trap controls, execute
//                          handshake, decoded head entry, illegal counter
// -----------------------------------------------------------------------------
module msrv32_decode_pipe
   import msrv32_pkg::*;
#(
   parameter int BUF_DEPTH = 2,
   parameter bit ENABLE_M  = 1'b1,
   parameter int CNT_W     = 16
) (
   input  logic                  ms_riscv32_mp_clk_in,
   input  logic                  ms_riscv32_mp_rst_in,
   msrv32_decode_pipe_if.slave   bus
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(BUF_DEPTH);

   logic clk;
   logic rst;
   assign clk = ms_riscv32_mp_clk_in;
   assign rst = ms_riscv32_mp_rst_in;

   // ---------------------------------------------------------------- decode
   dec_bundle_t in_dec;

   msrv32_instr_decode #(
      .ENABLE_M (ENABLE_M)
   ) u_decode (
      .instr (bus.instr_in),
      .dec   (in_dec)
   );

   // --------------------------------------------------------------- buffer
   buf_entry_t       mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [CNT_W-1:0] illegal_cnt;

   logic enq;
   logic deq;
   logic head_valid;

   assign head_valid          = (count != '0);
   // No bypass when full: a dequeue in the same cycle does not free a slot
   // for the incoming instruction.
   assign bus.instr_ready_out = (count < DEPTH_C) & ~bus.flush_in;
   assign enq                 = bus.instr_valid_in & bus.instr_ready_out;
   assign deq                 = head_valid & bus.dec_ready_in;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush_in) begin
         // Flush wins over any concurrent enqueue/dequeue
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
         if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({enq, deq})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; occupancy is tracked
   // by count, so stale slot contents are never observed as valid.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[wr_ptr] <= '{pc: bus.pc_in, instr: bus.instr_in, dec: in_dec};
      end
   end

   // Saturating count of accepted illegal instructions; survives flush
   always_ff @(posedge clk) begin
      if (rst) begin
         illegal_cnt <= '0;
      end else if (enq && in_dec.illegal && (illegal_cnt != '1)) begin
         illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
   end

   // --------------------------------------------------------------- outputs
   buf_entry_t  head;
   dec_bundle_t head_dec;

   assign head     = mem[rd_ptr];
   // Every control output is zero while the buffer is empty
   assign head_dec = head_valid ? head.dec : '0;

   assign bus.dec_valid_out     = head_valid;
   assign bus.pc_out            = head.pc;
   assign bus.instr_out         = head.instr;
   assign bus.alu_opcode_out    = head_dec.alu_opcode;
   assign bus.mul_div_out       = head_dec.mul_div;
   assign bus.mem_wr_req_out    = head_dec.is_store & head_valid & ~bus.trap_taken_in;
   assign bus.load_size_out     = head_dec.load_size;
   assign bus.load_unsigned_out = head_dec.load_unsigned;
   assign bus.alu_src_out       = head_dec.alu_src;
   assign bus.iadder_src_out    = head_dec.iadder_src;
   assign bus.rf_wr_en_out      = head_dec.rf_wr_en;
   assign bus.csr_wr_en_out     = head_dec.csr_wr_en;
   assign bus.csr_op_out        = head_dec.csr_op;
   assign bus.wb_mux_sel_out    = head_dec.wb_mux_sel;
   assign bus.imm_type_out      = head_dec.imm_type;
   assign bus.illegal_instr_out = head_dec.illegal;
   assign bus.illegal_cnt_out   = illegal_cnt;

endmodule

// File: tb/tb_msrv32_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_msrv32_decode_pipe
// Two instances share one stimulus stream: u_dut_m (ENABLE_M=1, CNT_W=16) and
// u_dut_n (ENABLE_M=0, CNT_W=2), both BUF_DEPTH=2. Expected head entries are
// pushed when an instruction is offered in a cycle where it must be accepted,
// and popped by a negedge monitor whenever the head is consumed.
// -----------------------------------------------------------------------------
module tb_msrv32_decode_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        instr_valid;
   logic        flush;
   logic        trap;
   logic        dec_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   msrv32_decode_pipe_if #(.CNT_W(16)) if_m ();
   msrv32_decode_pipe_if #(.CNT_W(2))  if_n ();

   assign if_m.instr_in       = instr;
   assign if_m.pc_in          = pc;
   assign if_m.instr_valid_in = instr_valid;
   assign if_m.flush_in       = flush;
   assign if_m.trap_taken_in  = trap;
   assign if_m.dec_ready_in   = dec_ready;
   assign if_n.instr_in       = instr;
   assign if_n.pc_in          = pc;
   assign if_n.instr_valid_in = instr_valid;
   assign if_n.flush_in       = flush;
   assign if_n.trap_taken_in  = trap;
   assign if_n.dec_ready_in   = dec_ready;

   msrv32_decode_pipe #(.BUF_DEPTH(2), .ENABLE_M(1'b1), .CNT_W(16)) u_dut_m (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .bus                  (if_m.slave)
   );

   msrv32_decode_pipe #(.BUF_DEPTH(2), .ENABLE_M(1'b0), .CNT_W(2)) u_dut_n (
      .ms_riscv32_mp_clk_in (clk),
      .ms_riscv32_mp_rst_in (rst),
      .bus                  (if_n.slave)
   );

   // ------------------------------------------------------------ scoreboard
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [3:0]  alu;
      logic [2:0]  imm;
      logic [2:0]  wb;
      logic        rf_m, mul_m, ill_m;
      logic        rf_n, mul_n, ill_n;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [3:0] alu,
                       input logic [2:0] imm, input logic [2:0] wb,
                       input logic rf_m, input logic mul_m, input logic ill_m,
                       input logic rf_n, input logic mul_n, input logic ill_n);
      exp_t e;
      e.pc = p; e.instr = i; e.alu = alu; e.imm = imm; e.wb = wb;
      e.rf_m = rf_m; e.mul_m = mul_m; e.ill_m = ill_m;
      e.rf_n = rf_n; e.mul_n = mul_n; e.ill_n = ill_n;
      sb.push_back(e);
   endtask

   // Consumed head entries are compared against the oldest expectation
   always @(negedge clk) begin
      if (!rst && dec_ready && if_m.dec_valid_out) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_underflow: observed head pc=%0h expected no entry", if_m.pc_out);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check($sformatf("m.pc@%0h", e.pc),      if_m.pc_out,            e.pc);
            check($sformatf("m.instr@%0h", e.pc),   if_m.instr_out,         e.instr);
            check($sformatf("m.alu@%0h", e.pc),     32'(if_m.alu_opcode_out), 32'(e.alu));
            check($sformatf("m.imm@%0h", e.pc),     32'(if_m.imm_type_out),   32'(e.imm));
            check($sformatf("m.wb@%0h", e.pc),      32'(if_m.wb_mux_sel_out), 32'(e.wb));
            check($sformatf("m.rf@%0h", e.pc),      32'(if_m.rf_wr_en_out),   32'(e.rf_m));
            check($sformatf("m.mul@%0h", e.pc),     32'(if_m.mul_div_out),    32'(e.mul_m));
            check($sformatf("m.ill@%0h", e.pc),     32'(if_m.illegal_instr_out), 32'(e.ill_m));
            check($sformatf("n.valid@%0h", e.pc),   32'(if_n.dec_valid_out),  32'd1);
            check($sformatf("n.pc@%0h", e.pc),      if_n.pc_out,            e.pc);
            check($sformatf("n.rf@%0h", e.pc),      32'(if_n.rf_wr_en_out),   32'(e.rf_n));
            check($sformatf("n.mul@%0h", e.pc),     32'(if_n.mul_div_out),    32'(e.mul_n));
            check($sformatf("n.ill@%0h", e.pc),     32'(if_n.illegal_instr_out), 32'(e.ill_n));
         end
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                        input logic r, input logic f, input logic t);
      instr_valid = v; instr = i; pc = p; dec_ready = r; flush = f; trap = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] I_ADDI5 = 32'h0050_0093;  // addi x1,x0,5
   localparam logic [31:0] I_ADDI7 = 32'h0070_0093;  // addi x1,x0,7
   localparam logic [31:0] I_ADDIA = 32'h00A0_0093;  // addi x1,x0,10
   localparam logic [31:0] I_ADD   = 32'h0020_81B3;  // add x3,x1,x2
   localparam logic [31:0] I_SUB   = 32'h4020_81B3;  // sub x3,x1,x2
   localparam logic [31:0] I_LW    = 32'h0080_A283;  // lw x5,8(x1)
   localparam logic [31:0] I_SW    = 32'h0020_A623;  // sw x2,12(x1)
   localparam logic [31:0] I_MUL   = 32'h0220_81B3;  // mul x3,x1,x2
   localparam logic [31:0] I_SLLIB = 32'h4010_9093;  // slli with funct7=0100000
   localparam logic [31:0] I_SRAI  = 32'h4010_5093;  // srai x1,x0,1

   initial begin
      rst = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      check("rst.valid_m", 32'(if_m.dec_valid_out), 32'd0);
      check("rst.rf_m",    32'(if_m.rf_wr_en_out),  32'd0);
      check("rst.cnt_m",   32'(if_m.illegal_cnt_out), 32'd0);
      rst = 1'b0;
      #1;
      check("rst.ready_m", 32'(if_m.instr_ready_out), 32'd1);

      // ADDI with execute ready: one cycle latency
      drive(1'b1, I_ADDI5, 32'h100, 1'b1, 1'b0, 1'b0);
      push(32'h100, I_ADDI5, 4'b0000, 3'b001, 3'b000, 1, 0, 0, 1, 0, 0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check("addi.valid_m", 32'(if_m.dec_valid_out), 32'd1);
      tick();
      check("addi.drained", 32'(if_m.dec_valid_out), 32'd0);

      // Fill with execute stalled; no bypass when full
      drive(1'b1, I_ADD, 32'h104, 1'b0, 1'b0, 1'b0);
      push(32'h104, I_ADD, 4'b0000, 3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
      tick();
      drive(1'b1, I_SUB, 32'h108, 1'b0, 1'b0, 1'b0);
      push(32'h108, I_SUB, 4'b1000, 3'b000, 3'b000, 1, 0, 0, 1, 0, 0);
      tick();
      drive(1'b1, I_LW, 32'h10C, 1'b0, 1'b0, 1'b0);
      #1;
      check("full.ready_m", 32'(if_m.instr_ready_out), 32'd0);
      tick();
      drive(1'b1, I_LW, 32'h10C, 1'b1, 1'b0, 1'b0);
      #1;
      check("full_deq.ready_m", 32'(if_m.instr_ready_out), 32'd0);
      tick();
      drive(1'b1, I_LW, 32'h10C, 1'b1, 1'b0, 1'b0);
      push(32'h10C, I_LW, 4'b0010, 3'b001, 3'b001, 1, 0, 0, 1, 0, 0);
      #1;
      check("one_free.ready_m", 32'(if_m.instr_ready_out), 32'd1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("fill.drained", 32'(if_m.dec_valid_out), 32'd0);

      // Store request gated by trap_taken_in
      drive(1'b1, I_SW, 32'h200, 1'b0, 1'b0, 1'b0);
      push(32'h200, I_SW, 4'b0010, 3'b010, 3'b000, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
      #1;
      check("sw_trap.memwr_m", 32'(if_m.mem_wr_req_out), 32'd0);
      check("sw_trap.memwr_n", 32'(if_n.mem_wr_req_out), 32'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      #1;
      check("sw.memwr_m", 32'(if_m.mem_wr_req_out), 32'd1);
      check("sw.memwr_n", 32'(if_n.mem_wr_req_out), 32'd1);
      check("sw.imm_m",   32'(if_m.imm_type_out),   32'b010);
      tick();
      check("sw.memwr_empty", 32'(if_m.mem_wr_req_out), 32'd0);

      // MUL: legal with M, illegal without
      drive(1'b1, I_MUL, 32'h300, 1'b1, 1'b0, 1'b0);
      push(32'h300, I_MUL, 4'b0000, 3'b000, 3'b000, 1, 1, 0, 0, 0, 1);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("mul.cnt_m", 32'(if_m.illegal_cnt_out), 32'd0);
      check("mul.cnt_n", 32'(if_n.illegal_cnt_out), 32'd1);

      // Flush with an instruction offered: buffer empties, offer dropped
      drive(1'b1, I_ADDI5, 32'h400, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, I_ADDIA, 32'h408, 1'b0, 1'b1, 1'b0);
      #1;
      check("flush.ready_m", 32'(if_m.instr_ready_out), 32'd0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("flush.valid_m", 32'(if_m.dec_valid_out), 32'd0);
      check("flush.valid_n", 32'(if_n.dec_valid_out), 32'd0);
      check("flush.rf_m",    32'(if_m.rf_wr_en_out),  32'd0);
      check("flush.imm_m",   32'(if_m.imm_type_out),  32'd0);
      check("flush.ready_m2", 32'(if_m.instr_ready_out), 32'd1);
      drive(1'b1, I_ADDI7, 32'h40C, 1'b1, 1'b0, 1'b0);
      push(32'h40C, I_ADDI7, 4'b0000, 3'b001, 3'b000, 1, 0, 0, 1, 0, 0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();

      // Illegal burst: counter saturation at 3 for CNT_W=2
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 32'h0, 32'h500 + 32'(4 * k), 1'b1, 1'b0, 1'b0);
         push(32'h500 + 32'(4 * k), 32'h0, 4'b0000, 3'b000, 3'b000, 0, 0, 1, 0, 0, 1);
         tick();
      end
      drive(1'b1, I_SLLIB, 32'h514, 1'b1, 1'b0, 1'b0);
      push(32'h514, I_SLLIB, 4'b1001, 3'b001, 3'b000, 0, 0, 1, 0, 0, 1);
      tick();
      drive(1'b1, I_SRAI, 32'h518, 1'b1, 1'b0, 1'b0);
      push(32'h518, I_SRAI, 4'b1101, 3'b001, 3'b000, 1, 0, 0, 1, 0, 0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
      tick();
      check("burst.cnt_m", 32'(if_m.illegal_cnt_out), 32'd6);
      check("burst.cnt_n", 32'(if_n.illegal_cnt_out), 32'd3);

      // Reset mid-stream drops buffered entries and clears the counter
      drive(1'b1, I_ADDI5, 32'h600, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      #1;
      check("mid.valid_pre", 32'(if_m.dec_valid_out), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("mid.valid_m", 32'(if_m.dec_valid_out),   32'd0);
      check("mid.cnt_m",   32'(if_m.illegal_cnt_out), 32'd0);
      check("mid.cnt_n",   32'(if_n.illegal_cnt_out), 32'd0);
      check("mid.ready_m", 32'(if_m.instr_ready_out), 32'd1);

      dec_ready = 1'b1;
      repeat (2) tick();
      check("sb.empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
